grf_wb_queue: RTL and testbench

//   Writer side of the GRF write port: buffers register-writeback requests (wa, wd, pc) in a FIFO
//   and issues at most one write per cycle onto the GRF WE/WA/WD/WPC inputs.

---
 rtl/grf_wb_queue.sv | 128 ++++++++++++
 tb/tb_grf_wb_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/grf_wb_queue.sv
// GRF write-port queue: buffers writeback requests and issues at most one GRF write per cycle,
// with a youngest-value pending-write lookup for decode. Optional trace: GRF_WB_DISPLAY_EN.
module grf_wb_queue #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_wa,
  input  logic [31:0] in_wd,
  input  logic [31:0] in_pc,
  input  logic        wb_hold,
  output logic        WE,
  output logic [4:0]  WA,
  output logic [31:0] WD,
  output logic [31:0] WPC,
  input  logic [4:0]  chk_addr_1,
  input  logic [4:0]  chk_addr_2,
  output logic        chk_hit_1,
  output logic        chk_hit_2,
  output logic [31:0] chk_data_1,
  output logic [31:0] chk_data_2
);

  localparam int unsigned CW = PTR_W + 1;
  localparam logic [CW-1:0] CountFull = CW'(DEPTH);
  localparam logic [CW-1:0] CountOne = CW'(1);
  localparam logic [PTR_W-1:0] PtrOne = PTR_W'(1);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [4:0]       wa_q [DEPTH];
  logic [31:0]      wd_q [DEPTH];
  logic [31:0]      pc_q [DEPTH];

  logic             empty;
  logic             push;
  logic [PTR_W-1:0] idx;

  assign empty    = (count_q == '0);
  assign in_ready = (count_q != CountFull);
  // Writes to r0 complete the handshake but are discarded.
  assign push     = in_valid && in_ready && (in_wa != 5'd0);
  assign WE       = !empty && !wb_hold;
  assign WA       = empty ? 5'd0  : wa_q[rd_ptr_q];
  assign WD       = empty ? 32'd0 : wd_q[rd_ptr_q];
  assign WPC      = empty ? 32'd0 : pc_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      valid_d  = '0;
    end else begin
      if (WE) begin
        rd_ptr_d          = rd_ptr_q + PtrOne;
        valid_d[rd_ptr_q] = 1'b0;
      end
      if (push) begin
        wr_ptr_d          = wr_ptr_q + PtrOne;
        valid_d[wr_ptr_q] = 1'b1;
      end
      unique case ({push, WE})
        2'b10:   count_d = count_q + CountOne;
        2'b01:   count_d = count_q - CountOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      if (push && !flush) begin
        wa_q[wr_ptr_q] <= in_wa;
        wd_q[wr_ptr_q] <= in_wd;
        pc_q[wr_ptr_q] <= in_pc;
      end
    end
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    chk_hit_1  = 1'b0;
    chk_hit_2  = 1'b0;
    chk_data_1 = '0;
    chk_data_2 = '0;
    idx        = rd_ptr_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (valid_q[idx] && (chk_addr_1 != 5'd0) && (wa_q[idx] == chk_addr_1)) begin
        chk_hit_1  = 1'b1;
        chk_data_1 = wd_q[idx];
      end
      if (valid_q[idx] && (chk_addr_2 != 5'd0) && (wa_q[idx] == chk_addr_2)) begin
        chk_hit_2  = 1'b1;
        chk_data_2 = wd_q[idx];
      end
    end
  end

`ifdef GRF_WB_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (reset && WE) begin
      $display("@%h: $%d <= %h", WPC, WA, WD);
    end
  end
`endif

endmodule

// File: tb/tb_grf_wb_queue.sv
// Directed self-checking bench for grf_wb_queue (DEPTH=4).
module tb_grf_wb_queue;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_wa;
  logic [31:0] in_wd;
  logic [31:0] in_pc;
  logic        wb_hold;
  logic        WE;
  logic [4:0]  WA;
  logic [31:0] WD;
  logic [31:0] WPC;
  logic [4:0]  chk_addr_1;
  logic [4:0]  chk_addr_2;
  logic        chk_hit_1;
  logic        chk_hit_2;
  logic [31:0] chk_data_1;
  logic [31:0] chk_data_2;

  int n_cmp = 0;
  int n_err = 0;

  grf_wb_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_wa      (in_wa),
    .in_wd      (in_wd),
    .in_pc      (in_pc),
    .wb_hold    (wb_hold),
    .WE         (WE),
    .WA         (WA),
    .WD         (WD),
    .WPC        (WPC),
    .chk_addr_1 (chk_addr_1),
    .chk_addr_2 (chk_addr_2),
    .chk_hit_1  (chk_hit_1),
    .chk_hit_2  (chk_hit_2),
    .chk_data_1 (chk_data_1),
    .chk_data_2 (chk_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven there.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pc);
    in_valid = 1'b1;
    in_wa    = wa;
    in_wd    = wd;
    in_pc    = pc;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    int  exp_wa;
    int  nxt;
    logic acc;

    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_wa = 5'd9; in_wd = 32'd1; in_pc = 32'd0;
    wb_hold = 1'b0; chk_addr_1 = 5'd9; chk_addr_2 = 5'd0;

    // Reset held for two edges with a live request
    cyc();
    cyc();
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    check("rst_we", WE, 0);
    check("rst_ready", in_ready, 1);
    check("rst_hit1", chk_hit_1, 0);
    check("rst_wa", WA, 0);
    cyc();
    @(negedge clk);
    check("rst_empty_we", WE, 0);
    cyc();

    // Order: two pushes, no pass-through
    in_valid = 1'b1; in_wa = 5'd3; in_wd = 32'd11; in_pc = 32'h3000;
    @(negedge clk);
    check("ord_nopass", WE, 0);
    cyc();
    in_wa = 5'd5; in_wd = 32'd22; in_pc = 32'h3004;
    @(negedge clk);
    check("ord_we0", WE, 1);
    check("ord_wa0", WA, 3);
    check("ord_wd0", WD, 11);
    check("ord_pc0", WPC, 32'h3000);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    check("ord_we1", WE, 1);
    check("ord_wa1", WA, 5);
    check("ord_wd1", WD, 22);
    check("ord_pc1", WPC, 32'h3004);
    cyc();
    @(negedge clk);
    check("ord_done_we", WE, 0);
    check("ord_done_wa", WA, 0);
    cyc();

    // Full and wrap: fill under hold, then drain 10 with pushes pending
    wb_hold = 1'b1;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'(100 + i), 32'(i * 4));
    @(negedge clk);
    check("full_ready", in_ready, 0);
    check("full_hold_we", WE, 0);
    check("full_head_wa", WA, 1);
    cyc();
    wb_hold = 1'b0;
    exp_wa  = 1;
    nxt     = 5;
    for (int c = 0; c < 40; c++) begin
      in_valid = (nxt <= 10);
      in_wa    = 5'(nxt);
      in_wd    = 32'(100 + nxt);
      in_pc    = 32'(nxt * 4);
      @(negedge clk);
      if (c == 0) begin
        check("full_we_ready", in_ready, 0);
        check("full_we", WE, 1);
      end
      if (WE) begin
        check("drain_wa", WA, 32'(exp_wa));
        check("drain_wd", WD, 32'(100 + exp_wa));
        exp_wa++;
      end
      acc = in_valid && in_ready;
      cyc();
      if (acc) nxt++;
    end
    in_valid = 1'b0;
    check("drain_total", 32'(exp_wa), 11);
    check("drain_pushed", 32'(nxt), 11);

    // Bypass: youngest of two matches, incoming request not visible
    wb_hold = 1'b1;
    push(5'd7, 32'hAA, 32'h100);
    push(5'd7, 32'hBB, 32'h104);
    chk_addr_1 = 5'd7;
    chk_addr_2 = 5'd0;
    @(negedge clk);
    check("byp_hit1", chk_hit_1, 1);
    check("byp_data1", chk_data_1, 32'hBB);
    check("byp_hit2_zero", chk_hit_2, 0);
    check("byp_data2_zero", chk_data_2, 0);
    cyc();
    chk_addr_2 = 5'd7;
    in_valid = 1'b1; in_wa = 5'd7; in_wd = 32'hCC; in_pc = 32'h108;
    @(negedge clk);
    check("byp_incoming", chk_data_2, 32'hBB);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    check("byp_after_push", chk_data_2, 32'hCC);
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    @(negedge clk);
    check("byp_flushed", chk_hit_1, 0);

    // Zero address: accepted, never issued
    cyc();
    wb_hold = 1'b0;
    in_valid = 1'b1; in_wa = 5'd0; in_wd = 32'd5; in_pc = 32'h200;
    @(negedge clk);
    check("zero_ready", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("zero_no_we", WE, 0);
      cyc();
    end

    // Flush drops queue and the push offered with it
    wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) push(5'(10 + i), 32'(i), 32'(i));
    flush = 1'b1; in_valid = 1'b1; in_wa = 5'd9; in_wd = 32'h99;
    cyc();
    flush = 1'b0; in_valid = 1'b0; wb_hold = 1'b0;
    chk_addr_1 = 5'd9; chk_addr_2 = 5'd10;
    @(negedge clk);
    check("flush_we", WE, 0);
    check("flush_wa", WA, 0);
    check("flush_hit_new", chk_hit_1, 0);
    check("flush_hit_old", chk_hit_2, 0);
    check("flush_ready", in_ready, 1);
    cyc();

    // Reset mid-drain
    wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) push(5'(20 + i), 32'(i + 7), 32'(i));
    wb_hold = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    check("mid_we_pre", WE, 1);
    check("mid_wa_pre", WA, 20);
    cyc();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("mid_no_we", WE, 0);
      check("mid_wa", WA, 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
